spdif_tx: RTL and testbench
===========================

# spdif_tx

S/PDIF (IEC 60958 consumer) transmitter: the encoding counterpart of the S/PDIF receiver. It pulls stereo 24-bit samples from an upstream source through the same pop/ack handshake used by the DAC driver. It builds 192-frame blocks with preambles, V/U/C/P bits and biphase-mark coding, and drives a single serial line. It sits on the 24.576 MHz domain beside the DAC driver as a digital output tap of the mixer.

## Interface
Parameters:
- `DEFAULT_RATE`, 2'b00: rate used when `rate_i` is 2'b11 (reserved).

Ports:
- `clk245760`, in, 1: 24.576 MHz clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `rate_i`, in, 2: output rate. 00 = 48 kHz, 01 = 96 kHz, 10 = 192 kHz, 11 = `DEFAULT_RATE`.
- `pop_o`, out, 2: one-cycle sample request. Bit 0 = left (subframe A), bit 1 = right (subframe B).
- `ack_i`, in, 2: data-valid strobe, one bit per channel, exactly 1 clk after the matching `pop_o`.
- `data_i`, in, 24: two's-complement sample, valid with `ack_i`.
- `cdata_i`, in, 192: channel-status block. Bit n is sent in frame n.
- `spdif_o`, out, 1: BMC line.
- `block_o`, out, 1: one-cycle pulse at the start of frame 0.
- `underrun_o`, out, 1: one-cycle pulse when a subframe has no data.

## Operation
- **Cell timing.** Frame = 2 subframes × 32 slots × 2 cells = 128 cells.
  - Cell-enable divider period: 4 / 2 / 1 clk for 48 / 96 / 192 kHz.
  - `rate_i` is latched only at block start (frame 0, subframe A, slot 0). A mid-block change takes effect at the next block.
- **Subframe slots.**
  - 0–3: preamble.
  - 4–27: audio, LSB first.
  - 28: V.
  - 29: U, always 0.
  - 30: C.
  - 31: P, chosen so slots 4–31 contain an even number of ones.
- **Preambles.** Cell patterns, given previous line level 0; inverted when the previous level is 1:
  - B = 11101000, for frame 0 subframe A.
  - M = 11100010, for other A subframes.
  - W = 11100100, for every B subframe.
- **BMC.** Slots 4–31: the line toggles at every bit start, and additionally at mid-bit when the bit is 1.
- **Fetch.**
  - At the first cell-enable of slot 0, `pop_o[ch]` = 1 for one cycle.
  - The sample is latched in the cycle `ack_i[ch]` = 1.
  - If no ack arrives before the slot-4 cell-enable (underrun): audio = 0, V = 1 for that subframe, and `underrun_o` pulses at the slot-4 cell-enable.
  - Otherwise V = 0.
  - An `ack_i` bit not matching the outstanding request is ignored.
- **State machine** (subframe sequencer): PRE (slots 0–3) → DATA (4–27) → AUX (28–31), then back to PRE with the channel toggled. The frame counter 0..191 increments after subframe B and wraps 191 → 0.
- **Reset** (also mid-frame): in the cycle after `rst` is sampled high, `spdif_o`, `pop_o`, `block_o` and `underrun_o` are all 0. Divider, slot, frame and channel counters clear, and the previous line level is 0. Operation restarts at frame 0 subframe A with preamble B.

## Timing
- Cycle 0 is the first cycle with `rst` low. In cycle 0:
  - `pop_o[0]` = 1.
  - `block_o` = 1.
  - The first cell is computed.
- `spdif_o` is registered: the first cell (1) is visible from cycle 1.
- Output latency from cell-enable to line is 1 clk.
- Subframe length: 256 / 128 / 64 clk. Frame length: 512 / 256 / 128 clk. Block length: 192 frames.
- Pops are spaced by exactly one subframe period, and `pop_o[0]` and `pop_o[1]` are never high together.

## Configuration
- `SPDIF_TX_CSTAT_EN`:
  - Defined: C bit = `cdata_i[frame]`. The same value is used for subframes A and B.
  - Undefined: C = 0 in every subframe, and `cdata_i` is unused (left for tie-off).
  - Parity always includes C.

## Structure
- The shared package holds:
  - the preamble constants B/M/W (8-bit cell patterns);
  - the rate encodings and the per-rate cell-divider constants;
  - the slot indices (AUDIO_LSB = 4, V = 28, U = 29, C = 30, P = 31);
  - the frames-per-block constant (192).
- Sub-module `spdif_tx_bmc`:
  - Inputs: cell-enable, a preamble-select/load strobe, and a 28-bit payload.
  - It serializes the payload, computes parity, tracks the line level and drives `spdif_o`.
- The top level owns the divider, the counters, the fetch handshake and underrun detection.

## Test plan
- **Reset, 48 kHz.** Release `rst` with ack on every pop; L = 24'h000001, R = 24'h000000.
  - `pop_o` = 01 at cycle 0 and `block_o` pulses at cycle 0.
  - The first 8 cells are 11101000, 4 clk each.
  - Decoded frame 0 gives L = 1, R = 0, V = 0, P = 1 (L) / 0 (R), with W in subframe B.
  - Frame 1 subframe A uses M.
- **Rate 192 kHz**, constant L = 24'h800000.
  - Subframe spacing between pops is 64 clk and a frame is 128 clk.
  - Every decoded left sample = 24'h800000, P = 1.
- **Underrun.** Withhold `ack_i[1]` for frame 3.
  - Frame 3 subframe B carries audio 0 and V = 1.
  - `underrun_o` pulses once.
  - Frame 4 is back to V = 0.
- **Channel status.** With `SPDIF_TX_CSTAT_EN` defined and `cdata_i` = 192'h1 | (1 << 191): C = 1 in frames 0 and 191 (both subframes), and 0 elsewhere. Without the macro: all C = 0.
- **Rate change and block wrap.** Switch `rate_i` 00 → 01 in frame 100.
  - Timing stays at 512 clk/frame until the frame 191 → 0 wrap, then becomes 256 clk/frame.
  - `block_o` pulses at the wrap and B is sent.
- **Reset mid-frame.** Assert `rst` at slot 15 of subframe B.
  - The next cycle shows `spdif_o` = 0 and `pop_o` = 00.
  - After release, the sequence is identical to the first test.

Source files
------------

// File: rtl/spdif_tx_pkg.sv
`default_nettype none
// ==========================================================================
// spdif_tx_pkg : preambles, rate/divider encodings, slot map, FSM types
// Rev 1.0
// ==========================================================================
package spdif_tx_pkg;

  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  localparam logic [1:0] RATE_48K  = 2'b00;
  localparam logic [1:0] RATE_96K  = 2'b01;
  localparam logic [1:0] RATE_192K = 2'b10;
  localparam logic [1:0] RATE_RSVD = 2'b11;

  localparam logic [2:0] CELL_DIV_48K  = 3'd4;
  localparam logic [2:0] CELL_DIV_96K  = 3'd2;
  localparam logic [2:0] CELL_DIV_192K = 3'd1;

  localparam int unsigned SLOT_AUDIO_LSB = 4;
  localparam int unsigned SLOT_V         = 28;
  localparam int unsigned SLOT_U         = 29;
  localparam int unsigned SLOT_C         = 30;
  localparam int unsigned SLOT_P         = 31;
  localparam int unsigned AUDIO_W        = SLOT_V - SLOT_AUDIO_LSB;
  localparam int unsigned PAYLOAD_W      = SLOT_P - SLOT_AUDIO_LSB + 1;

  localparam int unsigned FRAMES_PER_BLOCK = 192;

  typedef enum logic [1:0] {
    PRE_SEL_B = 2'd0,
    PRE_SEL_M = 2'd1,
    PRE_SEL_W = 2'd2
  } pre_sel_e;

  typedef enum logic [1:0] {
    ST_PRE  = 2'd0,
    ST_DATA = 2'd1,
    ST_AUX  = 2'd2
  } seq_state_e;

  // Divider reload value (period - 1); anything unknown falls back to 48 kHz.
  function automatic logic [1:0] cell_div_m1(input logic [1:0] rate);
    logic [2:0] div;
    case (rate)
      RATE_96K:  div = CELL_DIV_96K;
      RATE_192K: div = CELL_DIV_192K;
      default:   div = CELL_DIV_48K;
    endcase
    return 2'(div - 3'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spdif_tx_bmc.sv
`default_nettype none
// ==========================================================================
// spdif_tx_bmc : preamble/payload serializer, parity and biphase-mark line
// Rev 1.0
// ==========================================================================
module spdif_tx_bmc
  import spdif_tx_pkg::*;
(
  input  logic                 clk245760,
  input  logic                 rst,
  input  logic                 cell_en_i,
  input  logic                 pre_load_i,
  input  pre_sel_e             pre_sel_i,
  input  logic                 pay_load_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 spdif_o
);

  logic                 line_q, line_d;
  logic                 inv_q, inv_cur;
  logic [5:0]           cnt_q, cnt_cur;
  logic [7:0]           pre_q, pre_pat, pat_cur;
  logic [PAYLOAD_W-1:0] sh_q, sh_d, bits_cur, payload_p;

  always_comb begin
    case (pre_sel_i)
      PRE_SEL_M: pre_pat = PRE_M;
      PRE_SEL_W: pre_pat = PRE_W;
      default:   pre_pat = PRE_B;
    endcase
  end

  // The P position arrives as 0 and is replaced so slots 4..31 carry even ones.
  always_comb begin
    payload_p            = payload_i;
    payload_p[PAYLOAD_W-1] = ^payload_i;
  end

  assign cnt_cur  = pre_load_i ? 6'd0 : cnt_q;
  assign pat_cur  = pre_load_i ? pre_pat : pre_q;
  assign inv_cur  = pre_load_i ? line_q : inv_q;
  assign bits_cur = pay_load_i ? payload_p : sh_q;

  always_comb begin
    line_d = line_q;
    sh_d   = sh_q;
    if (cnt_cur < 6'd8) begin
      line_d = pat_cur[~cnt_cur[2:0]] ^ inv_cur;
    end else if (!cnt_cur[0]) begin
      line_d = ~line_q;
      sh_d   = bits_cur;
    end else begin
      line_d = line_q ^ bits_cur[0];
      sh_d   = bits_cur >> 1;
    end
  end

  always_ff @(posedge clk245760) begin
    if (rst) begin
      line_q <= 1'b0;
      inv_q  <= 1'b0;
      cnt_q  <= 6'd0;
      pre_q  <= 8'd0;
      sh_q   <= '0;
    end else if (cell_en_i) begin
      line_q <= line_d;
      cnt_q  <= cnt_cur + 6'd1;
      sh_q   <= sh_d;
      if (pre_load_i) begin
        pre_q <= pre_pat;
        inv_q <= line_q;
      end
    end
  end

  assign spdif_o = line_q;

endmodule
`default_nettype wire

// File: rtl/spdif_tx.sv
`default_nettype none
// ==========================================================================
// spdif_tx : IEC 60958 consumer transmitter (divider, sequencer, fetch)
// Option: SPDIF_TX_CSTAT_EN sends cdata_i[frame] as the C bit.
// Rev 1.0
// ==========================================================================
module spdif_tx
  import spdif_tx_pkg::*;
#(
  parameter logic [1:0] DEFAULT_RATE = RATE_48K
) (
  input  logic         clk245760,
  input  logic         rst,
  input  logic [1:0]   rate_i,
  output logic [1:0]   pop_o,
  input  logic [1:0]   ack_i,
  input  logic [23:0]  data_i,
  input  logic [191:0] cdata_i,
  output logic         spdif_o,
  output logic         block_o,
  output logic         underrun_o
);

  logic [1:0]           div_q, div_d, rate_q, rate_in;
  logic                 cell_q, cell_d, ch_q, ch_d;
  logic [4:0]           slot_q, slot_d;
  logic [7:0]           frame_q, frame_d;
  seq_state_e           state_q, state_d;
  logic                 pend_q, req_ch_q, got_q;
  logic [AUDIO_W-1:0]   sample_q;
  logic                 cell_en, sf_start, blk_start, pay_start, c_bit;
  pre_sel_e             pre_sel;
  logic [PAYLOAD_W-1:0] payload;

  assign rate_in   = (rate_i == RATE_RSVD) ? DEFAULT_RATE : rate_i;
  assign cell_en   = (div_q == 2'd0);
  assign sf_start  = cell_en && !cell_q && (state_q == ST_PRE) && (slot_q == 5'd0);
  assign blk_start = sf_start && !ch_q && (frame_q == 8'd0);
  assign pay_start = cell_en && !cell_q && (state_q == ST_DATA) && (slot_q == 5'(SLOT_AUDIO_LSB));

  // The block-start cell already runs at the newly latched rate.
  assign div_d = cell_en ? cell_div_m1(blk_start ? rate_in : rate_q) : div_q - 2'd1;

  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    slot_d  = slot_q;
    ch_d    = ch_q;
    frame_d = frame_q;
    if (cell_en) begin
      cell_d = ~cell_q;
      if (cell_q) begin
        slot_d = slot_q + 5'd1;
        case (state_q)
          ST_PRE:  if (slot_q == 5'(SLOT_AUDIO_LSB - 1)) state_d = ST_DATA;
          ST_DATA: if (slot_q == 5'(SLOT_V - 1)) state_d = ST_AUX;
          ST_AUX: begin
            if (slot_q == 5'(SLOT_P)) begin
              state_d = ST_PRE;
              ch_d    = ~ch_q;
              if (ch_q) begin
                frame_d = (frame_q == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_q + 8'd1;
              end
            end
          end
          default: state_d = ST_PRE;
        endcase
      end
    end
  end

  always_ff @(posedge clk245760) begin
    if (rst) begin
      div_q   <= 2'd0;
      rate_q  <= RATE_48K;
      cell_q  <= 1'b0;
      slot_q  <= 5'd0;
      ch_q    <= 1'b0;
      frame_q <= 8'd0;
      state_q <= ST_PRE;
    end else begin
      div_q   <= div_d;
      cell_q  <= cell_d;
      slot_q  <= slot_d;
      ch_q    <= ch_d;
      frame_q <= frame_d;
      state_q <= state_d;
      if (blk_start) rate_q <= rate_in;
    end
  end

  // Only the ack bit of the outstanding request counts, and only until slot 4.
  always_ff @(posedge clk245760) begin
    if (rst) begin
      pend_q   <= 1'b0;
      req_ch_q <= 1'b0;
      got_q    <= 1'b0;
      sample_q <= '0;
    end else if (sf_start) begin
      pend_q   <= 1'b1;
      req_ch_q <= ch_q;
      got_q    <= 1'b0;
    end else if (pend_q && ack_i[req_ch_q]) begin
      pend_q   <= 1'b0;
      got_q    <= 1'b1;
      sample_q <= data_i;
    end else if (pay_start) begin
      pend_q   <= 1'b0;
    end
  end

`ifdef SPDIF_TX_CSTAT_EN
  assign c_bit = cdata_i[frame_q];
`else
  logic cdata_unused;
  assign c_bit        = 1'b0;
  assign cdata_unused = ^cdata_i;
`endif

  always_comb begin
    payload                                 = '0;
    payload[AUDIO_W-1:0]                    = got_q ? sample_q : '0;
    payload[SLOT_V - SLOT_AUDIO_LSB]        = ~got_q;
    payload[SLOT_U - SLOT_AUDIO_LSB]        = 1'b0;
    payload[SLOT_C - SLOT_AUDIO_LSB]        = c_bit;
  end

  assign pre_sel = ch_q ? PRE_SEL_W : ((frame_q == 8'd0) ? PRE_SEL_B : PRE_SEL_M);

  spdif_tx_bmc u_bmc (
    .clk245760  (clk245760),
    .rst        (rst),
    .cell_en_i  (cell_en),
    .pre_load_i (sf_start),
    .pre_sel_i  (pre_sel),
    .pay_load_i (pay_start),
    .payload_i  (payload),
    .spdif_o    (spdif_o)
  );

  assign pop_o      = rst ? 2'b00 : {sf_start & ch_q, sf_start & ~ch_q};
  assign block_o    = blk_start & ~rst;
  assign underrun_o = pay_start & ~got_q & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_spdif_tx.sv
`default_nettype none
// ==========================================================================
// tb_spdif_tx : directed bench, decodes the BMC line subframe by subframe
// Rev 1.0
// ==========================================================================
module tb_spdif_tx;

  localparam logic [7:0] PB = 8'b1110_1000;
  localparam logic [7:0] PM = 8'b1110_0010;
  localparam logic [7:0] PW = 8'b1110_0100;

  logic         clk245760 = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   rate_i = 2'b00;
  logic [1:0]   pop_o;
  logic [1:0]   ack_i = 2'b00;
  logic [23:0]  data_i = 24'h0;
  logic [191:0] cdata_i = '0;
  logic         spdif_o, block_o, underrun_o;

  int           checks = 0;
  int           errors = 0;
  logic         lvl = 1'b0;
  logic [23:0]  l_val = 24'h0;
  logic [23:0]  r_val = 24'h0;
  int           skip_r = -1;
  int           rpop = 0;

  always #5 clk245760 = ~clk245760;

  spdif_tx dut (
    .clk245760  (clk245760),
    .rst        (rst),
    .rate_i     (rate_i),
    .pop_o      (pop_o),
    .ack_i      (ack_i),
    .data_i     (data_i),
    .cdata_i    (cdata_i),
    .spdif_o    (spdif_o),
    .block_o    (block_o),
    .underrun_o (underrun_o)
  );

  // Upstream source: answers each pop one clock later, except a chosen right pop.
  always begin : ack_model
    logic [1:0] p;
    @(negedge clk245760);
    p = pop_o;
    if (rst) rpop = 0;
    @(posedge clk245760);
    #1;
    ack_i  = 2'b00;
    data_i = 24'hA5A5A5;
    if (p[0]) begin
      ack_i  = 2'b01;
      data_i = l_val;
    end
    if (p[1]) begin
      if (rpop != skip_r) begin
        ack_i  = 2'b10;
        data_i = r_val;
      end
      rpop++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cexp(input int f);
`ifdef SPDIF_TX_CSTAT_EN
    return (f == 0) || (f == 191);
`else
    return (f < 0);
`endif
  endfunction

  function automatic string sf_tag(input int f, input logic ch, input string what);
    return $sformatf("f%0d%s %s", f, ch ? "B" : "A", what);
  endfunction

  // Samples every cycle of one subframe (64 cells of per clocks each).
  task automatic cap_sf(input int per, output logic [63:0] cells, output logic hold_ok,
                        output logic [1:0] npop, output logic nblk, output int stray,
                        output int urn);
    hold_ok = 1'b1; stray = 0; urn = 0; npop = 2'b00; nblk = 1'b0; cells = '0;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < per; k++) begin
        @(negedge clk245760);
        if (k == 0) cells[63-i] = spdif_o;
        else if (spdif_o !== cells[63-i]) hold_ok = 1'b0;
        if (underrun_o === 1'b1) urn++;
        if (i == 63 && k == per - 1) begin
          npop = pop_o;
          nblk = block_o;
        end else if (pop_o !== 2'b00 || block_o !== 1'b0) begin
          stray++;
        end
      end
    end
  endtask

  task automatic decode(input logic [63:0] c, output logic [7:0] pre,
                        output logic [27:0] bits, output logic ok);
    logic a, b;
    ok  = 1'b1;
    pre = c[63:56] ^ {8{lvl}};
    lvl = c[56];
    for (int j = 0; j < 28; j++) begin
      a = c[55-2*j];
      b = c[54-2*j];
      if (a === lvl) ok = 1'b0;
      bits[j] = a ^ b;
      lvl = b;
    end
  endtask

  task automatic chk_sf(input int f, input logic ch, input int per, input logic [7:0] epre,
                        input logic [23:0] eaud, input logic ev, input logic ec, input int eurn,
                        input logic [1:0] enpop, input logic enblk);
    logic [63:0] cells;
    logic        hold_ok, bmc_ok, nblk;
    logic [1:0]  npop;
    int          stray, urn;
    logic [7:0]  pre;
    logic [27:0] bits;
    logic [26:0] low;
    cap_sf(per, cells, hold_ok, npop, nblk, stray, urn);
    decode(cells, pre, bits, bmc_ok);
    low = {ec, 1'b0, ev, eaud};
    check(sf_tag(f, ch, "preamble"), pre, epre);
    check(sf_tag(f, ch, "slots4-31"), bits, {^low, low});
    check(sf_tag(f, ch, "bmc"), bmc_ok, 1'b1);
    check(sf_tag(f, ch, "cell hold"), hold_ok, 1'b1);
    check(sf_tag(f, ch, "stray pop"), stray, 0);
    check(sf_tag(f, ch, "underrun"), urn, eurn);
    check(sf_tag(f, ch, "next pop"), npop, enpop);
    check(sf_tag(f, ch, "next block"), nblk, enblk);
  endtask

  task automatic run_frame(input int f, input int per, input logic ur);
    chk_sf(f, 1'b0, per, (f == 0) ? PB : PM, l_val, 1'b0, cexp(f), 0, 2'b10, 1'b0);
    chk_sf(f, 1'b1, per, PW, ur ? 24'h0 : r_val, ur, cexp(f), ur ? 1 : 0, 2'b01, f == 191);
  endtask

  task automatic release_rst();
    @(posedge clk245760);
    #1;
    rst = 1'b0;
    lvl = 1'b0;
    @(negedge clk245760);
    check("cycle0 pop", pop_o, 2'b01);
    check("cycle0 block", block_o, 1'b1);
    check("cycle0 line", spdif_o, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " line"}, spdif_o, 1'b0);
    check({tag, " pop"}, pop_o, 2'b00);
    check({tag, " block"}, block_o, 1'b0);
    check({tag, " underrun"}, underrun_o, 1'b0);
  endtask

  initial begin
    cdata_i      = 192'd1;
    cdata_i[191] = 1'b1;

    // 48 kHz, L = 1, R = 0, right sample of frame 3 withheld
    l_val  = 24'h000001;
    r_val  = 24'h000000;
    skip_r = 3;
    repeat (3) @(negedge clk245760);
    check_reset_outputs("reset");
    release_rst();
    for (int f = 0; f < 5; f++) run_frame(f, 4, f == 3);

    // reset in slot 15 of frame 5 subframe B; reserved rate maps to 48 kHz
    chk_sf(5, 1'b0, 4, PM, l_val, 1'b0, cexp(5), 0, 2'b10, 1'b0);
    repeat (121) @(negedge clk245760);
    rst    = 1'b1;
    rate_i = 2'b11;
    skip_r = -1;
    @(negedge clk245760);
    check_reset_outputs("midframe reset");
    @(negedge clk245760);
    release_rst();
    run_frame(0, 4, 1'b0);
    run_frame(1, 4, 1'b0);

    // 192 kHz
    rst    = 1'b1;
    rate_i = 2'b10;
    l_val  = 24'h800000;
    r_val  = 24'h123456;
    repeat (2) @(negedge clk245760);
    release_rst();
    for (int f = 0; f < 4; f++) run_frame(f, 1, 1'b0);

    // full block at 96 kHz, switch to 192 kHz in frame 100, effective after wrap
    rst    = 1'b1;
    rate_i = 2'b01;
    l_val  = 24'h00F00F;
    r_val  = 24'hFFFFFF;
    repeat (2) @(negedge clk245760);
    release_rst();
    for (int f = 0; f < 192; f++) begin
      if (f == 100) rate_i = 2'b10;
      run_frame(f, 2, 1'b0);
    end
    run_frame(0, 1, 1'b0);
    run_frame(1, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
